canvas_access_arbiter: RTL and testbench
========================================

Name: canvas_access_arbiter

Overview:
- Owns the 32x32 one-bit drawing canvas and arbitrates its single word port between four requesters:
  - VGA row fetch
  - canvas clear sequencer
  - mouse pen pixel writes
  - snapshot export to the DNN classifier
- Sits between the mouse/VGA front end and the classifier. It replaces direct bit-level writes into the flat image vector with a sequenced, coherent store.

Parameters:
- C_DIM, 32: canvas edge in pixels; word width and word count. Must be a power of two.
- C_AW, 5: log2(C_DIM); address width of X/Y/row indices.

Ports:
- clkVga  in  1  pixel/system clock; all state on rising edge.
- iRstN  in  1  asynchronous, active-low reset.
- iVgaRdEn  in  1  VGA row read strobe.
- iVgaRow  in  C_AW  word index to read.
- oVgaRowData  out  C_DIM  word read; valid one cycle after iVgaRdEn.
- iPenReq  in  1  pen write request; held until ack.
- iPenX  in  C_AW  pixel X (word index).
- iPenY  in  C_AW  pixel Y (bit within word).
- iPenVal  in  1  pixel value to write.
- oPenAck  out  1  one-cycle pulse, cycle after commit.
- iClrReq  in  1  clear request pulse.
- iSnapReq  in  1  snapshot request pulse.
- oSnapValid  out  1  one-cycle pulse when oImage updated.
- oImage  out  C_DIM*C_DIM  snapshot; bit index {X,Y}.
- oBusy  out  1  high in CLEAR or SNAP state.

Behaviour:
- Storage: C_DIM words of C_DIM bits. Word X, bit Y = pixel (X,Y).
- Reset (async, any time incl. mid-clear/snap):
  - all words 0, state IDLE, pending flags 0, indices 0
  - outputs oVgaRowData=0, oPenAck=0, oSnapValid=0, oImage=0, oBusy=0
- Port usage: at most one access per cycle. Fixed priority: VGA read > clear write > pen write > snapshot read.
- VGA read: always granted when iVgaRdEn=1. oVgaRowData <= word[iVgaRow] at that edge (latency 1). It holds its value when not reading.
- FSM states: IDLE, CLEAR, SNAP.
  - IDLE -> CLEAR on iClrReq or clrPend.
  - IDLE -> SNAP on iSnapReq or snapPend, only if no clear is pending.
- Simultaneous iClrReq and iSnapReq in IDLE: clear runs first, snapPend is set, and the snapshot starts on return to IDLE.
- CLEAR:
  - each granted cycle writes word[clrIdx]=0, then clrIdx++
  - a cycle taken by a VGA read stalls clrIdx
  - after clrIdx=C_DIM-1 is written -> IDLE, clrIdx=0
  - iClrReq during CLEAR is ignored
- SNAP:
  - each granted cycle copies word[snapIdx] into oImage[snapIdx*C_DIM +: C_DIM], then snapIdx++
  - VGA read stalls it
  - after the last word: oSnapValid=1 for one cycle, state -> IDLE
  - iClrReq during SNAP sets clrPend; iSnapReq during SNAP is ignored
  - oImage changes only during SNAP; it is stable between snapshots
- Pen:
  - granted only in IDLE, with no VGA read, no clear/snap start that cycle, and oPenAck=0
  - grant writes word[iPenX][iPenY]=iPenVal; oPenAck=1 the next cycle
  - requester must drop iPenReq in the ack cycle; no regrant while oPenAck=1
  - pen is blocked during CLEAR/SNAP, so snapshots are coherent
  - writing a pixel already at the same value still acks
- Latency with no VGA contention: clear takes C_DIM cycles; snapshot takes C_DIM cycles plus the oSnapValid pulse.

Optional Feature:
- Macro CANVAS_ERASE_EN.
- Defined: iPenVal is honoured (0 erases).
- Undefined: iPenVal is ignored and every pen write stores 1. The port still exists but is unused.

Decomposition:
- Shared package canvas_pkg: C_DIM, C_AW, state encoding (IDLE/CLEAR/SNAP).
- One sub-module, canvas_store: word register array with async reset, one write port (addr, bit mask, data), one registered read port, one combinational read for snapshot. The arbiter FSM and priority mux stay in the top.

Test Plan:
- Pen write X=3,Y=7, val 1 -> oPenAck pulses the next cycle; VGA read row 3 the cycle after returns 32'h0000_0080.
- Pen (5,5) then iSnapReq with no VGA traffic -> oSnapValid after 33 cycles, oImage[5*32+5]=1 and all other bits 0.
- Fill several pixels, then iClrReq with iVgaRdEn toggling every other cycle -> oBusy for 64 cycles; afterwards all rows read 0; pen requests during CLEAR are acked only after oBusy falls.
- iClrReq and iSnapReq in the same cycle after drawing (2,2) -> clear completes, then snapshot runs; oSnapValid with oImage all 0.
- Assert iRstN low at clrIdx=10 mid-clear -> all outputs 0, state IDLE; a subsequent snapshot yields 0 and oBusy low until a new request.
- CANVAS_ERASE_EN defined: write (1,1)=1 then (1,1)=0 -> row 1 reads 0. Undefined: row 1 reads 32'h2.

Source files
------------

// File: rtl/canvas_pkg.sv
// Shared definitions for the drawing canvas: geometry and arbiter state encoding.
package canvas_pkg;

    localparam int C_DIM = 32;
    localparam int C_AW  = 5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_SNAP  = 2'd2;

endpackage

// File: rtl/canvas_store.sv
// Canvas word store: DIM words of DIM bits, one masked write port,
// one registered read port (VGA) and one combinational read (snapshot).
module canvas_store
    import canvas_pkg::*;
#(
    parameter int DIM = C_DIM,
    parameter int AW  = C_AW
) (
    input  logic           clkVga,
    input  logic           iRstN,
    input  logic           wr_en,
    input  logic [AW-1:0]  wr_addr,
    input  logic [DIM-1:0] wr_mask,
    input  logic [DIM-1:0] wr_data,
    input  logic           rd_en,
    input  logic [AW-1:0]  rd_addr,
    output logic [DIM-1:0] rd_data,
    input  logic [AW-1:0]  snap_addr,
    output logic [DIM-1:0] snap_data
);

    logic [DIM-1:0] words [DIM];

    // Masked write: only the bits selected by wr_mask take wr_data.
    always_ff @(posedge clkVga or negedge iRstN) begin
        if (!iRstN) begin
            for (int i = 0; i < DIM; i++) begin
                words[i] <= '0;
            end
        end else if (wr_en) begin
            words[wr_addr] <= (words[wr_addr] & ~wr_mask) | (wr_data & wr_mask);
        end
    end

    // Registered read; the last fetched word is held between reads.
    always_ff @(posedge clkVga or negedge iRstN) begin
        if (!iRstN) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= words[rd_addr];
        end
    end

    assign snap_data = words[snap_addr];

endmodule

// File: rtl/canvas_access_arbiter.sv
// Canvas access arbiter: owns the canvas store and shares its single word
// port between VGA row fetch, clear sequencer, pen writes and snapshot export.
// Fixed priority: VGA read > clear > pen > snapshot.
// Optional macro CANVAS_ERASE_EN: when defined, iPenVal is written (0 erases);
// otherwise every pen write stores 1 and iPenVal has no effect.
module canvas_access_arbiter
    import canvas_pkg::*;
(
    input  logic                     clkVga,
    input  logic                     iRstN,
    input  logic                     iVgaRdEn,
    input  logic [C_AW-1:0]          iVgaRow,
    output logic [C_DIM-1:0]         oVgaRowData,
    input  logic                     iPenReq,
    input  logic [C_AW-1:0]          iPenX,
    input  logic [C_AW-1:0]          iPenY,
    input  logic                     iPenVal,
    output logic                     oPenAck,
    input  logic                     iClrReq,
    input  logic                     iSnapReq,
    output logic                     oSnapValid,
    output logic [C_DIM*C_DIM-1:0]   oImage,
    output logic                     oBusy
);

    localparam logic [C_AW-1:0] LAST_IDX = C_AW'(C_DIM - 1);

    logic [1:0]             state;
    logic [C_AW-1:0]        clr_idx;
    logic [C_AW-1:0]        snap_idx;
    logic                   clr_pend;
    logic                   snap_pend;
    logic                   pen_ack;
    logic                   snap_valid;
    logic [C_DIM*C_DIM-1:0] image;

    logic                   start_clear;
    logic                   start_snap;
    logic                   clr_go;
    logic                   snap_go;
    logic                   pen_grant;
    logic                   pen_bit;

    logic                   wr_en;
    logic [C_AW-1:0]        wr_addr;
    logic [C_DIM-1:0]       wr_mask;
    logic [C_DIM-1:0]       wr_data;
    logic [C_DIM-1:0]       snap_data;

`ifdef CANVAS_ERASE_EN
    assign pen_bit = iPenVal;
`else
    assign pen_bit = iPenVal | 1'b1;
`endif

    assign start_clear = (state == ST_IDLE) && (iClrReq || clr_pend);
    assign start_snap  = (state == ST_IDLE) && !start_clear && (iSnapReq || snap_pend);
    assign clr_go      = (state == ST_CLEAR) && !iVgaRdEn;
    assign snap_go     = (state == ST_SNAP) && !iVgaRdEn;
    assign pen_grant   = (state == ST_IDLE) && !iVgaRdEn && !start_clear
                         && !start_snap && !pen_ack && iPenReq;

    // Write-port mux: clear and pen never coincide because they live in different states.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_mask = '0;
        wr_data = '0;
        if (clr_go) begin
            wr_en   = 1'b1;
            wr_addr = clr_idx;
            wr_mask = '1;
            wr_data = '0;
        end else if (pen_grant) begin
            wr_en   = 1'b1;
            wr_addr = iPenX;
            wr_mask = C_DIM'(1) << iPenY;
            wr_data = {C_DIM{pen_bit}};
        end
    end

    canvas_store #(
        .DIM (C_DIM),
        .AW  (C_AW)
    ) u_store (
        .clkVga    (clkVga),
        .iRstN     (iRstN),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_mask   (wr_mask),
        .wr_data   (wr_data),
        .rd_en     (iVgaRdEn),
        .rd_addr   (iVgaRow),
        .rd_data   (oVgaRowData),
        .snap_addr (snap_idx),
        .snap_data (snap_data)
    );

    // Arbiter FSM: sequences clear and snapshot, tracks deferred requests and pen ack.
    always_ff @(posedge clkVga or negedge iRstN) begin
        if (!iRstN) begin
            state      <= ST_IDLE;
            clr_idx    <= '0;
            snap_idx   <= '0;
            clr_pend   <= 1'b0;
            snap_pend  <= 1'b0;
            pen_ack    <= 1'b0;
            snap_valid <= 1'b0;
            image      <= '0;
        end else begin
            snap_valid <= 1'b0;
            pen_ack    <= pen_grant;
            case (state)
                ST_IDLE: begin
                    if (start_clear) begin
                        state    <= ST_CLEAR;
                        clr_pend <= 1'b0;
                        clr_idx  <= '0;
                        if (iSnapReq) begin
                            snap_pend <= 1'b1;
                        end
                    end else if (start_snap) begin
                        state     <= ST_SNAP;
                        snap_pend <= 1'b0;
                        snap_idx  <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (iSnapReq) begin
                        snap_pend <= 1'b1;
                    end
                    if (clr_go) begin
                        if (clr_idx == LAST_IDX) begin
                            state   <= ST_IDLE;
                            clr_idx <= '0;
                        end else begin
                            clr_idx <= clr_idx + 1'b1;
                        end
                    end
                end
                ST_SNAP: begin
                    if (iClrReq) begin
                        clr_pend <= 1'b1;
                    end
                    if (snap_go) begin
                        image[snap_idx*C_DIM +: C_DIM] <= snap_data;
                        if (snap_idx == LAST_IDX) begin
                            snap_valid <= 1'b1;
                            state      <= ST_IDLE;
                            snap_idx   <= '0;
                        end else begin
                            snap_idx <= snap_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign oPenAck    = pen_ack;
    assign oSnapValid = snap_valid;
    assign oImage     = image;
    assign oBusy      = (state != ST_IDLE);

endmodule

// File: tb/tb_canvas_access_arbiter.sv
// Self-checking bench for canvas_access_arbiter: a pixel model supplies
// expected row words and snapshot images through scoreboard queues.
module tb_canvas_access_arbiter;
    import canvas_pkg::*;

    logic                   clkVga = 1'b0;
    logic                   iRstN;
    logic                   iVgaRdEn;
    logic [C_AW-1:0]        iVgaRow;
    logic [C_DIM-1:0]       oVgaRowData;
    logic                   iPenReq;
    logic [C_AW-1:0]        iPenX;
    logic [C_AW-1:0]        iPenY;
    logic                   iPenVal;
    logic                   oPenAck;
    logic                   iClrReq;
    logic                   iSnapReq;
    logic                   oSnapValid;
    logic [C_DIM*C_DIM-1:0] oImage;
    logic                   oBusy;

    int compared   = 0;
    int mismatched = 0;

    logic [C_DIM-1:0]       model [C_DIM];
    logic [C_DIM-1:0]       rd_q [$];
    logic [C_DIM*C_DIM-1:0] snap_q [$];

    canvas_access_arbiter dut (
        .clkVga      (clkVga),
        .iRstN       (iRstN),
        .iVgaRdEn    (iVgaRdEn),
        .iVgaRow     (iVgaRow),
        .oVgaRowData (oVgaRowData),
        .iPenReq     (iPenReq),
        .iPenX       (iPenX),
        .iPenY       (iPenY),
        .iPenVal     (iPenVal),
        .oPenAck     (oPenAck),
        .iClrReq     (iClrReq),
        .iSnapReq    (iSnapReq),
        .oSnapValid  (oSnapValid),
        .oImage      (oImage),
        .oBusy       (oBusy)
    );

    // Free-running pixel clock.
    always #5 clkVga = ~clkVga;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clkVga);
        #1;
    endtask

    task automatic modelClear();
        for (int i = 0; i < C_DIM; i++) begin
            model[i] = '0;
        end
    endtask

    function automatic logic [C_DIM*C_DIM-1:0] modelImage();
        logic [C_DIM*C_DIM-1:0] img;
        for (int x = 0; x < C_DIM; x++) begin
            img[x*C_DIM +: C_DIM] = model[x];
        end
        return img;
    endfunction

    task automatic vgaRead(input int row);
        logic [C_DIM-1:0] exp_word;
        iVgaRdEn = 1'b1;
        iVgaRow  = C_AW'(row);
        rd_q.push_back(model[row]);
        step();
        iVgaRdEn = 1'b0;
        exp_word = rd_q.pop_front();
        checkOutput($sformatf("vga_row%0d", row), 64'(oVgaRowData), 64'(exp_word));
    endtask

    task automatic penWrite(input int x, input int y, input logic v, output int wait_cycles);
        bit got;
        got         = 1'b0;
        wait_cycles = 0;
        iPenReq     = 1'b1;
        iPenX       = C_AW'(x);
        iPenY       = C_AW'(y);
        iPenVal     = v;
        for (int i = 0; i < 300 && !got; i++) begin
            step();
            wait_cycles++;
            if (oPenAck) got = 1'b1;
        end
        iPenReq = 1'b0;
        if (got) begin
`ifdef CANVAS_ERASE_EN
            model[x][y] = v;
`else
            model[x][y] = 1'b1;
`endif
        end else begin
            checkOutput("pen_ack_timeout", 64'd0, 64'd1);
        end
    endtask

    task automatic doClear();
        bit done;
        done    = 1'b0;
        iClrReq = 1'b1;
        step();
        iClrReq = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            step();
            if (!oBusy) done = 1'b1;
        end
        if (!done) checkOutput("clear_timeout", 64'd0, 64'd1);
        modelClear();
    endtask

    task automatic doSnap(input bit with_clear, output int cycles);
        bit got;
        logic [C_DIM*C_DIM-1:0] exp_img;
        got    = 1'b0;
        cycles = 0;
        if (with_clear) begin
            modelClear();
            iClrReq = 1'b1;
        end
        snap_q.push_back(modelImage());
        iSnapReq = 1'b1;
        for (int i = 0; i < 300 && !got; i++) begin
            step();
            cycles++;
            iSnapReq = 1'b0;
            iClrReq  = 1'b0;
            if (oSnapValid) got = 1'b1;
        end
        exp_img = snap_q.pop_front();
        if (got) begin
            for (int x = 0; x < C_DIM; x++) begin
                checkOutput($sformatf("snap_row%0d", x), 64'(oImage[x*C_DIM +: C_DIM]),
                            64'(exp_img[x*C_DIM +: C_DIM]));
            end
            step();
            checkOutput("snap_pulse_drop", 64'(oSnapValid), 64'd0);
            checkOutput("snap_busy_done", 64'(oBusy), 64'd0);
        end else begin
            checkOutput("snap_timeout", 64'd0, 64'd1);
        end
    endtask

    task automatic applyStimulus();
        int wc;
        int busy_count;
        int ack_while_busy;
        bit ack_seen;

        // Reset state
        iRstN    = 1'b0;
        iVgaRdEn = 1'b0;
        iVgaRow  = '0;
        iPenReq  = 1'b0;
        iPenX    = '0;
        iPenY    = '0;
        iPenVal  = 1'b0;
        iClrReq  = 1'b0;
        iSnapReq = 1'b0;
        modelClear();
        repeat (2) step();
        checkOutput("rst_vga", 64'(oVgaRowData), 64'd0);
        checkOutput("rst_ack", 64'(oPenAck), 64'd0);
        checkOutput("rst_snapvalid", 64'(oSnapValid), 64'd0);
        checkOutput("rst_image_any", 64'(|oImage), 64'd0);
        checkOutput("rst_busy", 64'(oBusy), 64'd0);
        @(negedge clkVga);
        iRstN = 1'b1;
        step();

        // Pen write then VGA read of the same row
        penWrite(3, 7, 1'b1, wc);
        checkOutput("pen_ack_latency", 64'(wc), 64'd1);
        vgaRead(3);
        checkOutput("pen_ack_pulse", 64'(oPenAck), 64'd0);
        checkOutput("row3_const", 64'(oVgaRowData), 64'h80);
        step();
        checkOutput("vga_hold", 64'(oVgaRowData), 64'h80);

        // Clear with VGA contention every other cycle and a pen request pending
        penWrite(10, 0, 1'b1, wc);
        penWrite(31, 31, 1'b1, wc);
        penWrite(0, 31, 1'b1, wc);
        iClrReq = 1'b1;
        step();
        iClrReq = 1'b0;
        checkOutput("clr_enter_busy", 64'(oBusy), 64'd1);
        busy_count     = oBusy ? 1 : 0;
        ack_while_busy = 0;
        ack_seen       = 1'b0;
        iPenReq = 1'b1;
        iPenX   = 5'd4;
        iPenY   = 5'd4;
        iPenVal = 1'b1;
        for (int k = 0; k < 300 && !ack_seen; k++) begin
            iVgaRdEn = oBusy && (k % 2 == 0);
            iVgaRow  = C_AW'(k % C_DIM);
            step();
            if (oBusy) busy_count++;
            if (oPenAck) begin
                ack_seen = 1'b1;
                if (oBusy) ack_while_busy++;
            end
        end
        iPenReq  = 1'b0;
        iVgaRdEn = 1'b0;
        modelClear();
        if (ack_seen) model[4][4] = 1'b1;
        checkOutput("clr_busy_cycles", 64'(busy_count), 64'd64);
        checkOutput("clr_pen_ack_seen", 64'(ack_seen), 64'd1);
        checkOutput("clr_pen_ack_in_busy", 64'(ack_while_busy), 64'd0);
        for (int r = 0; r < C_DIM; r++) begin
            vgaRead(r);
        end

        // Snapshot of a single pixel with no VGA traffic
        doClear();
        penWrite(5, 5, 1'b1, wc);
        doSnap(1'b0, wc);
        checkOutput("snap_latency", 64'(wc), 64'd33);
        checkOutput("snap_bit55", 64'(oImage[5*C_DIM+5]), 64'd1);

        // Simultaneous clear and snapshot: clear first, then an empty snapshot
        penWrite(2, 2, 1'b1, wc);
        doSnap(1'b1, wc);
        checkOutput("clr_snap_latency", 64'(wc), 64'd66);

        // Asynchronous reset in the middle of a clear
        penWrite(6, 6, 1'b1, wc);
        doSnap(1'b0, wc);
        penWrite(7, 7, 1'b1, wc);
        iClrReq = 1'b1;
        step();
        iClrReq = 1'b0;
        repeat (10) step();
        checkOutput("midclr_busy", 64'(oBusy), 64'd1);
        iRstN = 1'b0;
        #1;
        modelClear();
        checkOutput("midrst_vga", 64'(oVgaRowData), 64'd0);
        checkOutput("midrst_ack", 64'(oPenAck), 64'd0);
        checkOutput("midrst_snapvalid", 64'(oSnapValid), 64'd0);
        checkOutput("midrst_image_any", 64'(|oImage), 64'd0);
        checkOutput("midrst_busy", 64'(oBusy), 64'd0);
        @(negedge clkVga);
        iRstN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("post_rst_idle%0d", i), 64'(oBusy), 64'd0);
        end
        doSnap(1'b0, wc);
        checkOutput("post_rst_snap_latency", 64'(wc), 64'd33);

        // Erase behaviour depends on CANVAS_ERASE_EN
        penWrite(1, 1, 1'b1, wc);
        penWrite(1, 1, 1'b0, wc);
        vgaRead(1);
`ifdef CANVAS_ERASE_EN
        checkOutput("erase_row1", 64'(oVgaRowData), 64'h0);
`else
        checkOutput("erase_row1", 64'(oVgaRowData), 64'h2);
`endif
    endtask

    initial begin
        applyStimulus();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
